// File: rtl/apb_width_bridge.sv
// APB4 width-down bridge: splits one wide upstream transfer into narrow downstream beats,
// skipping write beats whose byte strobes are all zero and aborting on a downstream error.
module apb_width_bridge #(
    parameter int ADDR_W    = 13,
    parameter int UP_DATA_W = 32,
    parameter int DN_DATA_W = 8
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    // upstream completer
    input  logic                   u_PSEL,
    input  logic                   u_PENABLE,
    input  logic                   u_PWRITE,
    input  logic [ADDR_W-1:0]      u_PADDR,
    input  logic [UP_DATA_W-1:0]   u_PWDATA,
    input  logic [UP_DATA_W/8-1:0] u_PSTRB,
    output logic                   u_PREADY,
    output logic [UP_DATA_W-1:0]   u_PRDATA,
    output logic                   u_PSLVERR,
    // downstream requester
    output logic                   d_PSEL,
    output logic                   d_PENABLE,
    output logic                   d_PWRITE,
    output logic [ADDR_W-1:0]      d_PADDR,
    output logic [DN_DATA_W-1:0]   d_PWDATA,
    output logic [DN_DATA_W/8-1:0] d_PSTRB,
    input  logic                   d_PREADY,
    input  logic [DN_DATA_W-1:0]   d_PRDATA,
    input  logic                   d_PSLVERR
);

    localparam int RATIO     = UP_DATA_W / DN_DATA_W;
    localparam int UP_STRB_W = UP_DATA_W / 8;
    localparam int DN_STRB_W = DN_DATA_W / 8;
    localparam int UP_LSB    = $clog2(UP_STRB_W);
    localparam int DN_LSB    = $clog2(DN_STRB_W);
    localparam int BEAT_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << UP_LSB) - 1);

    if (!(RATIO == 1 || RATIO == 2 || RATIO == 4 || RATIO == 8) ||
        (UP_DATA_W != RATIO * DN_DATA_W) || (DN_DATA_W % 8 != 0)) begin : g_bad_ratio
        $error("apb_width_bridge: UP_DATA_W/DN_DATA_W must be 1, 2, 4 or 8");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      addr_q;
    logic                   write_q;
    logic [UP_DATA_W-1:0]   wdata_q;
    logic [UP_STRB_W-1:0]   strb_q;
    logic [BEAT_W-1:0]      beat_q;
    logic                   err_q;
    logic [UP_DATA_W-1:0]   rbuf_q;
    logic                   after_done_q;

    logic                   accept;
    logic [RATIO-1:0]       remaining;
    logic                   pick_valid;
    logic [BEAT_W-1:0]      pick;

    // Lowest remaining active beat: from IDLE all lanes are candidates, later only lanes above beat_q.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        accept     = (state_q == IDLE) && u_PSEL && u_PENABLE && !after_done_q;
        remaining  = '0;
        pick_valid = 1'b0;
        pick       = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (state_q == IDLE)
                remaining[i] = !u_PWRITE || (|u_PSTRB[i*DN_STRB_W +: DN_STRB_W]);
            else
                remaining[i] = (!write_q || (|strb_q[i*DN_STRB_W +: DN_STRB_W])) && (i > int'(beat_q));
        end
        for (int i = RATIO - 1; i >= 0; i--) begin
            if (remaining[i]) begin
                pick_valid = 1'b1;
                pick       = BEAT_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        d_PSEL    = 1'b0;
        d_PENABLE = 1'b0;
        u_PREADY  = 1'b0;
        u_PSLVERR = 1'b0;
        case (state_q)
            IDLE:   if (accept) state_d = pick_valid ? SETUP : DONE;
            SETUP: begin
                d_PSEL  = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                d_PSEL    = 1'b1;
                d_PENABLE = 1'b1;
                if (d_PREADY) state_d = (d_PSLVERR || !pick_valid) ? DONE : SETUP;
            end
            DONE: begin
                u_PREADY  = 1'b1;
                u_PSLVERR = err_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!PRESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            // NOTE: the read buffer is explicitly cleared on reset because u_PRDATA exposes it directly.
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            strb_q       <= '0;
            beat_q       <= '0;
            err_q        <= 1'b0;
            rbuf_q       <= '0;
            after_done_q <= 1'b0;
        end else begin
            after_done_q <= (state_q == DONE);
            if (accept) begin
                addr_q  <= u_PADDR;
                write_q <= u_PWRITE;
                wdata_q <= u_PWDATA;
                strb_q  <= u_PSTRB;
                beat_q  <= '0;
                err_q   <= 1'b0;
                rbuf_q  <= '0;
            end
            if (state_d == SETUP) beat_q <= pick;
            // An erroring beat is not a fetched lane, so its data is dropped.
            if (state_q == ACCESS && d_PREADY) begin
                if (d_PSLVERR)     err_q <= 1'b1;
                else if (!write_q) rbuf_q[int'(beat_q)*DN_DATA_W +: DN_DATA_W] <= d_PRDATA;
            end
        end
    end

    assign d_PWRITE = write_q;
    assign d_PADDR  = (addr_q & ALIGN_MASK) | (ADDR_W'(beat_q) << DN_LSB);
    assign d_PWDATA = wdata_q[int'(beat_q)*DN_DATA_W +: DN_DATA_W];
    assign d_PSTRB  = write_q ? strb_q[int'(beat_q)*DN_STRB_W +: DN_STRB_W] : '0;
    assign u_PRDATA = rbuf_q;

endmodule

// File: tb/tb_apb_width_bridge.sv
// Bench for apb_width_bridge: directed cases with literal expectations plus randomized
// transfers scored against a transaction-level model of beats, data and completion cycle.
module tb_apb_width_bridge;

    localparam int ADDR_W = 13;
    localparam int UP_W   = 32;
    localparam int DN_W   = 8;
    localparam int RATIO  = UP_W / DN_W;
    localparam int UP_SW  = UP_W / 8;
    localparam int DN_SW  = DN_W / 8;

    logic              PCLK = 1'b0;
    logic              PRESETn = 1'b0;
    logic              u_PSEL = 1'b0, u_PENABLE = 1'b0, u_PWRITE = 1'b0;
    logic [ADDR_W-1:0] u_PADDR = '0;
    logic [UP_W-1:0]   u_PWDATA = '0;
    logic [UP_SW-1:0]  u_PSTRB = '0;
    logic              u_PREADY, u_PSLVERR;
    logic [UP_W-1:0]   u_PRDATA;
    logic              d_PSEL, d_PENABLE, d_PWRITE;
    logic [ADDR_W-1:0] d_PADDR;
    logic [DN_W-1:0]   d_PWDATA;
    logic [DN_SW-1:0]  d_PSTRB;
    logic              d_PREADY = 1'b0, d_PSLVERR = 1'b0;
    logic [DN_W-1:0]   d_PRDATA = '0;

    apb_width_bridge #(.ADDR_W(ADDR_W), .UP_DATA_W(UP_W), .DN_DATA_W(DN_W)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .u_PSEL(u_PSEL), .u_PENABLE(u_PENABLE), .u_PWRITE(u_PWRITE), .u_PADDR(u_PADDR),
        .u_PWDATA(u_PWDATA), .u_PSTRB(u_PSTRB), .u_PREADY(u_PREADY), .u_PRDATA(u_PRDATA),
        .u_PSLVERR(u_PSLVERR),
        .d_PSEL(d_PSEL), .d_PENABLE(d_PENABLE), .d_PWRITE(d_PWRITE), .d_PADDR(d_PADDR),
        .d_PWDATA(d_PWDATA), .d_PSTRB(d_PSTRB), .d_PREADY(d_PREADY), .d_PRDATA(d_PRDATA),
        .d_PSLVERR(d_PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    bit rst_at_edge = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge PCLK) begin
        cyc++;
        rst_at_edge = !PRESETn;
    end

    // Downstream completer behaviour for the current transfer, indexed by lane.
    logic [DN_W-1:0] plan_data [RATIO];
    int              plan_waits[RATIO];
    bit              plan_err  [RATIO];

    function automatic void set_plan(logic [UP_W-1:0] data, logic [15:0] waits, logic [RATIO-1:0] err);
        for (int i = 0; i < RATIO; i++) begin
            plan_data[i]  = data[i*DN_W +: DN_W];
            plan_waits[i] = int'(waits[i*4 +: 4]);
            plan_err[i]   = err[i];
        end
    endfunction

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DN_W-1:0]   wdata;
        logic [DN_SW-1:0]  strb;
        logic              write;
    } beat_t;

    typedef struct {
        int              done_cyc;
        logic [UP_W-1:0] prdata;
        logic            slverr;
    } txn_t;

    beat_t             exp_beats[$];
    txn_t              exp_txns[$];
    logic [ADDR_W-1:0] seen_addr[$];
    logic [DN_W-1:0]   seen_wdata[$];

    // Transaction model: which lanes run, in what order, and when the upstream side completes.
    function automatic void model(int c, logic wr, logic [ADDR_W-1:0] a, logic [UP_W-1:0] wd,
                                  logic [UP_SW-1:0] st);
        txn_t  t;
        beat_t b;
        int    t_cyc;
        int    base;
        logic [DN_SW-1:0] s;
        t_cyc    = c;
        t.prdata = '0;
        t.slverr = 1'b0;
        base     = (int'(a) / UP_SW) * UP_SW;
        for (int i = 0; i < RATIO; i++) begin
            s = st[i*DN_SW +: DN_SW];
            if (wr && s == '0) continue;
            b.addr  = ADDR_W'(base + i * DN_SW);
            b.wdata = wd[i*DN_W +: DN_W];
            b.strb  = wr ? s : '0;
            b.write = wr;
            exp_beats.push_back(b);
            t_cyc += 2 + plan_waits[i];
            if (plan_err[i]) begin
                t.slverr = 1'b1;
                break;
            end
            if (!wr) t.prdata[i*DN_W +: DN_W] = plan_data[i];
        end
        t.done_cyc = t_cyc + 1;
        exp_txns.push_back(t);
    endfunction

    // Downstream responder: counts wait states per beat, answers from the plan.
    int wcnt = 0;
    always @(posedge PCLK) begin
        #1;
        if (d_PSEL && !d_PENABLE) wcnt = plan_waits[int'(d_PADDR[1:0])];
        if (d_PSEL && d_PENABLE) begin
            if (wcnt == 0) begin
                d_PREADY  = 1'b1;
                d_PSLVERR = plan_err[int'(d_PADDR[1:0])];
                d_PRDATA  = plan_err[int'(d_PADDR[1:0])] ? '0 : plan_data[int'(d_PADDR[1:0])];
            end else begin
                wcnt--;
                d_PREADY  = 1'b0;
                d_PSLVERR = 1'($urandom);
                d_PRDATA  = DN_W'($urandom);
            end
        end else begin
            d_PREADY  = 1'($urandom);
            d_PSLVERR = 1'($urandom);
            d_PRDATA  = DN_W'($urandom);
        end
    end

    // Compare process: checks protocol, beats and completions every cycle against the model.
    bit    prev_setup = 1'b0, prev_wait = 1'b0;
    beat_t cur;
    txn_t  t_pop;
    always @(negedge PCLK) begin
        if (rst_at_edge) begin
            check("reset_outputs",
                  {d_PSEL, d_PENABLE, d_PWRITE, u_PREADY, u_PSLVERR, d_PADDR, d_PWDATA, d_PSTRB, u_PRDATA}, '0);
            exp_beats.delete();
            exp_txns.delete();
            prev_setup = 1'b0;
            prev_wait  = 1'b0;
        end else begin
            if (prev_setup || prev_wait) begin
                check("access_phase", {d_PSEL, d_PENABLE}, 2'b11);
                check("access_stable", {d_PADDR, d_PWDATA, d_PSTRB, d_PWRITE},
                      {cur.addr, cur.wdata, cur.strb, cur.write});
            end else begin
                check("penable_outside_access", d_PENABLE, 1'b0);
                if (d_PSEL) begin
                    seen_addr.push_back(d_PADDR);
                    seen_wdata.push_back(d_PWDATA);
                    if (exp_beats.size() == 0) begin
                        check("unexpected_beat", d_PSEL, 1'b0);
                    end else begin
                        cur = exp_beats.pop_front();
                        check("beat_addr", d_PADDR, cur.addr);
                        check("beat_wdata", d_PWDATA, cur.wdata);
                        check("beat_strb", d_PSTRB, cur.strb);
                        check("beat_write", d_PWRITE, cur.write);
                    end
                end
            end
            prev_setup = d_PSEL && !d_PENABLE;
            prev_wait  = d_PSEL && d_PENABLE && !d_PREADY;

            if (u_PREADY) begin
                if (exp_txns.size() == 0) begin
                    check("unexpected_pready", u_PREADY, 1'b0);
                end else begin
                    t_pop = exp_txns.pop_front();
                    check("done_cycle", cyc, t_pop.done_cyc);
                    check("prdata", u_PRDATA, t_pop.prdata);
                    check("pslverr", u_PSLVERR, t_pop.slverr);
                    check("beats_left", exp_beats.size(), 0);
                end
            end else begin
                check("pslverr_not_done", u_PSLVERR, 1'b0);
                if (exp_txns.size() != 0 && cyc >= exp_txns[0].done_cyc) begin
                    check("pready_missing", u_PREADY, 1'b1);
                    void'(exp_txns.pop_front());
                end
            end
        end
    end

    logic [UP_W-1:0] m_rdata;
    logic            m_err;
    int              m_lat;
    int              m_c;

    // Upstream requester; entered and left just after a rising edge.
    task automatic xfer(input logic wr, input logic [ADDR_W-1:0] a, input logic [UP_W-1:0] wd,
                        input logic [UP_SW-1:0] st, input int gap, input bit scramble, input bit linger);
        u_PSEL = 1'b1; u_PENABLE = 1'b0; u_PWRITE = wr; u_PADDR = a; u_PWDATA = wd; u_PSTRB = st;
        @(posedge PCLK); #1;
        u_PENABLE = 1'b1;
        m_c   = cyc;
        m_lat = -1;
        model(m_c, wr, a, wd, st);
        for (int k = 0; k < 200; k++) begin
            @(negedge PCLK);
            if (u_PREADY) begin
                m_lat   = cyc - m_c;
                m_rdata = u_PRDATA;
                m_err   = u_PSLVERR;
                break;
            end
            if (scramble && cyc > m_c) begin
                u_PWRITE = 1'($urandom); u_PADDR = ADDR_W'($urandom);
                u_PWDATA = $urandom;     u_PSTRB = UP_SW'($urandom);
            end
        end
        if (m_lat < 0) check("xfer_timeout", u_PREADY, 1'b1);
        @(posedge PCLK); #1;
        if (linger) @(negedge PCLK);
        u_PSEL = 1'b0; u_PENABLE = 1'b0;
        if (linger) begin @(posedge PCLK); #1; end
        repeat (gap) begin @(posedge PCLK); #1; end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [ADDR_W-1:0] ea[4];
        logic [DN_W-1:0]   ed[4];
        bit                found;
        logic              r_wr;
        logic [UP_SW-1:0]  r_st;
        logic [15:0]       r_w;
        logic [RATIO-1:0]  r_e;

        ea = '{13'h104, 13'h105, 13'h106, 13'h107};
        ed = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        set_plan(32'h0, 16'h0, '0);
        repeat (3) @(posedge PCLK);
        @(negedge PCLK) PRESETn = 1'b1;
        @(posedge PCLK); #1;

        // Full-strobe write: four beats, lane order, DONE at C+9.
        seen_addr.delete(); seen_wdata.delete();
        xfer(1'b1, 13'h0104, 32'hAABBCCDD, 4'hF, 1, 1'b0, 1'b0);
        check("r030_lat", m_lat, 9);
        check("r030_err", m_err, 1'b0);
        check("r030_nbeats", seen_addr.size(), 4);
        for (int i = 0; i < 4 && i < seen_addr.size(); i++) begin
            check("r030_addr", seen_addr[i], ea[i]);
            check("r030_wdata", seen_wdata[i], ed[i]);
        end

        // Sparse strobes: lanes 0 and 2 only.
        seen_addr.delete(); seen_wdata.delete();
        xfer(1'b1, 13'h0104, 32'hAABBCCDD, 4'h5, 1, 1'b0, 1'b0);
        check("r031_lat", m_lat, 5);
        check("r031_nbeats", seen_addr.size(), 2);
        if (seen_addr.size() == 2) begin
            check("r031_addr0", seen_addr[0], 13'h104);
            check("r031_addr1", seen_addr[1], 13'h106);
        end

        // No strobes: no downstream activity, DONE at C+1; held PENABLE after DONE is not re-accepted.
        seen_addr.delete(); seen_wdata.delete();
        xfer(1'b1, 13'h0104, 32'hAABBCCDD, 4'h0, 2, 1'b0, 1'b1);
        check("r032_lat", m_lat, 1);
        check("r032_nbeats", seen_addr.size(), 0);

        // Read with two wait states on beat 1.
        set_plan(32'h44332211, 16'h0020, '0);
        xfer(1'b0, 13'h0200, 32'h0, 4'h0, 1, 1'b1, 1'b0);
        check("r033_rdata", m_rdata, 32'h44332211);
        check("r033_lat", m_lat, 11);
        check("r033_err", m_err, 1'b0);

        // Read with error on beat 2: beat 3 skipped, lanes 0-1 returned.
        seen_addr.delete(); seen_wdata.delete();
        set_plan(32'h44332211, 16'h0000, 4'b0100);
        xfer(1'b0, 13'h0200, 32'h0, 4'h0, 1, 1'b0, 1'b0);
        check("r034_rdata", m_rdata, 32'h00002211);
        check("r034_err", m_err, 1'b1);
        check("r034_nbeats", seen_addr.size(), 3);
        check("r034_lat", m_lat, 7);

        // Reset during the access phase of beat 1 abandons the transfer.
        set_plan(32'h44332211, 16'h0030, '0);
        u_PSEL = 1'b1; u_PENABLE = 1'b0; u_PWRITE = 1'b0; u_PADDR = 13'h0300; u_PSTRB = '0;
        @(posedge PCLK); #1;
        u_PENABLE = 1'b1;
        model(cyc, 1'b0, 13'h0300, 32'h0, 4'h0);
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge PCLK);
            found = d_PSEL && d_PENABLE && (d_PADDR == 13'h0301);
        end
        check("r035_in_beat1", {d_PSEL, d_PENABLE, d_PADDR}, {2'b11, 13'h0301});
        PRESETn = 1'b0; u_PSEL = 1'b0; u_PENABLE = 1'b0;
        @(negedge PCLK);
        check("r035_psel_drop", d_PSEL, 1'b0);
        PRESETn = 1'b1;
        repeat (6) begin
            @(negedge PCLK);
            check("r035_no_pready", u_PREADY, 1'b0);
        end
        @(posedge PCLK); #1;
        set_plan(32'h8877_6655, 16'h0000, '0);
        xfer(1'b0, 13'h0300, 32'h0, 4'h0, 1, 1'b0, 1'b0);
        check("r035_after_rdata", m_rdata, 32'h88776655);
        check("r035_after_lat", m_lat, 9);

        // Randomized traffic scored by the compare process.
        for (int n = 0; n < 150; n++) begin
            r_wr = 1'($urandom);
            r_st = UP_SW'($urandom);
            for (int i = 0; i < RATIO; i++)
                r_w[i*4 +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 3)) : 4'h0;
            for (int i = 0; i < RATIO; i++)
                r_e[i] = ($urandom_range(0, 7) == 0);
            set_plan($urandom, r_w, r_e);
            xfer(r_wr, ADDR_W'($urandom), $urandom, r_st, $urandom_range(0, 2),
                 1'($urandom), ($urandom_range(0, 3) == 0));
        end

        repeat (4) @(posedge PCLK);
        check("final_model_drained", exp_txns.size() + exp_beats.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_width_bridge.md
APB_WIDTH_BRIDGE -- requirements
Module: apb_width_bridge

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 13, the byte address width on both sides.
REQ-002 The block SHALL have parameter UP_DATA_W, default 32, the upstream data width.
REQ-003 The block SHALL have parameter DN_DATA_W, default 8, the downstream data width; RATIO = UP_DATA_W/DN_DATA_W SHALL be a power of 2 from 1 to 8, and any other value SHALL be rejected at elaboration.
REQ-004 The block SHALL have port PCLK, input, 1 bit: the single clock.
REQ-005 The block SHALL have port PRESETn, input, 1 bit: synchronous active-low reset, sampled on the rising edge of PCLK.
REQ-006 The block SHALL have upstream APB4 completer inputs u_PSEL, u_PENABLE, u_PWRITE (1 bit each), u_PADDR (ADDR_W bits), u_PWDATA (UP_DATA_W bits) and u_PSTRB (UP_DATA_W/8 bits).
REQ-007 The block SHALL have upstream outputs u_PREADY (1 bit), u_PRDATA (UP_DATA_W bits) and u_PSLVERR (1 bit).
REQ-008 The block SHALL have downstream APB4 requester outputs d_PSEL, d_PENABLE, d_PWRITE (1 bit each), d_PADDR (ADDR_W bits), d_PWDATA (DN_DATA_W bits) and d_PSTRB (DN_DATA_W/8 bits).
REQ-009 The block SHALL have downstream inputs d_PREADY (1 bit), d_PRDATA (DN_DATA_W bits) and d_PSLVERR (1 bit).

Function
REQ-010 The FSM SHALL have states IDLE, SETUP, ACCESS and DONE.
REQ-011 In IDLE, when u_PSEL=1 and u_PENABLE=1, the block SHALL capture the upstream address, write flag, write data and strobes, clear the beat index and the error flag, and leave IDLE.
REQ-012 Beat i (0..RATIO-1) SHALL be active for a write when its upstream strobe slice u_PSTRB[i*DN_DATA_W/8 +: DN_DATA_W/8] is non-zero; for a read, every beat SHALL be active.
REQ-013 From IDLE or ACCESS, the block SHALL go to SETUP for the lowest remaining active beat, or to DONE if no active beat remains.
REQ-014 In SETUP the outputs SHALL be d_PSEL=1 and d_PENABLE=0; the next state SHALL be ACCESS unconditionally.
REQ-015 In ACCESS the outputs SHALL be d_PSEL=1 and d_PENABLE=1, and the block SHALL hold all d_* outputs stable until d_PREADY=1.
REQ-016 The beat address SHALL be d_PADDR = {captured PADDR[ADDR_W-1:log2(UP_DATA_W/8)], i, zeros in the low log2(DN_DATA_W/8) bits}, with little-endian lane mapping.
REQ-017 d_PWDATA and d_PSTRB SHALL carry the lane-i slices of the captured data and strobes; d_PSTRB SHALL be all zeros on reads.
REQ-018 On an ACCESS cycle with d_PREADY=1 during a read, d_PRDATA SHALL be written into read-buffer lane i.
REQ-019 On an ACCESS cycle with d_PREADY=1 and d_PSLVERR=1, the error flag SHALL be set, the remaining beats SHALL be aborted, and the next state SHALL be DONE.
REQ-020 Outside SETUP and ACCESS, d_PSEL and d_PENABLE SHALL be 0.
REQ-021 In DONE, u_PREADY SHALL be 1 for exactly that one cycle, u_PSLVERR SHALL equal the error flag, and u_PRDATA SHALL equal the read buffer (lanes not fetched read 0); the next state SHALL be IDLE.
REQ-022 u_PREADY SHALL be 0 in every state other than DONE, so upstream wait states are inserted while beats run.
REQ-023 On the cycle following DONE, IDLE SHALL NOT accept a transfer, because upstream PENABLE is still high from the completed transfer.
REQ-024 Upstream input changes while the block is not in IDLE SHALL be ignored.
REQ-025 Latency, zero-wait downstream: a transfer with N active beats sampled in IDLE at cycle C SHALL see u_PREADY=1 at cycle C+2N+1; N=0 gives C+1.
REQ-026 When RATIO=1, the block SHALL perform one pass-through beat with the same FSM timing.

Reset
REQ-027 While PRESETn=0 at a clock edge, the block SHALL go to IDLE and drive d_PSEL=0, d_PENABLE=0, d_PWRITE=0, u_PREADY=0 and u_PSLVERR=0.
REQ-028 Under reset, d_PADDR, d_PWDATA, d_PSTRB and u_PRDATA SHALL be 0, and the read buffer and error flag SHALL be cleared.
REQ-029 Reset asserted mid-transfer SHALL abandon it: d_PSEL SHALL drop on the next edge, and no u_PREADY SHALL be issued for the abandoned transfer.

Verification
REQ-030 Write 0xAABBCCDD to 0x0104 with PSTRB=0xF and zero-wait downstream -> 4 beats at 0x104/0x105/0x106/0x107 with data DD/CC/BB/AA, and u_PREADY at C+9 with u_PSLVERR=0.
REQ-031 Write with PSTRB=0x5 -> 2 beats only, at 0x104 and 0x106, and u_PREADY at C+5.
REQ-032 Write with PSTRB=0x0 -> no d_PSEL, and u_PREADY at C+1.
REQ-033 Read from 0x0200 with downstream returning 11,22,33,44 and 2 wait states on beat 1 -> u_PRDATA=0x44332211 and u_PREADY at C+11.
REQ-034 Read in which beat 2 returns d_PSLVERR=1 -> beat 3 not issued, u_PSLVERR=1, and u_PRDATA=0x00002211 (lanes 0-1 fetched).
REQ-035 PRESETn=0 during the ACCESS of beat 1 -> d_PSEL=0 next cycle, no u_PREADY, and a new transfer afterwards completes normally.
